// File: rtl/turf_mm_pkg.sv
// Shared definitions for the Xillybus mmreq/mmresp register-bus bridge:
// state encoding, status bit positions, default widths and fill values.
package turf_mm_pkg;

    typedef enum logic [2:0] {
        ADDR  = 3'd0,
        DATA  = 3'd1,
        BUS   = 3'd2,
        RESP0 = 3'd3,
        RESP1 = 3'd4
    } mm_state_e;

    localparam int unsigned WR_BIT        = 31;
    localparam int unsigned TO_BIT        = 30;
    localparam int unsigned ADR_WIDTH_DEF = 28;
    localparam logic [31:0] TO_FILL       = 32'hFFFF_FFFF;

    // Response header: address zero-extended, status flags in the top bits.
    function automatic logic [31:0] resp_word0(input logic wr, input logic to,
                                               input logic [29:0] adr);
        logic [31:0] w;
        w         = 32'(adr);
        w[WR_BIT] = wr;
        w[TO_BIT] = to;
        return w;
    endfunction

endpackage

// File: rtl/xil_mmreq_bridge.sv
// Bridges Xillybus mmreq/mmresp FIFO streams to a simple en/ack register bus.
// Optional bus timeout is enabled by defining XIL_MMREQ_BRIDGE_TIMEOUT_EN.
module xil_mmreq_bridge
    import turf_mm_pkg::*;
#(
    parameter int unsigned ADR_WIDTH      = ADR_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          req_dat_i,
    input  logic                 req_wr_i,
    output logic                 req_full_o,
    input  logic                 req_open_i,
    output logic [31:0]          resp_dat_o,
    input  logic                 resp_rd_i,
    output logic                 resp_empty_o,
    output logic                 en_o,
    output logic                 wr_o,
    input  logic                 ack_i,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic [31:0]          dat_o,
    input  logic [31:0]          dat_i
);

    if (ADR_WIDTH > 30 || ADR_WIDTH == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("xil_mmreq_bridge: ADR_WIDTH must be 1..30 and TIMEOUT_CYCLES nonzero");
    end

    mm_state_e            state_q, state_d;
    logic                 en_q, en_d;
    logic                 wr_q, wr_d;
    logic [ADR_WIDTH-1:0] adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [31:0]          rdat_q, rdat_d;
    logic [31:0]          resp_dat_q, resp_dat_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 tmo;
    logic                 accept;
    logic                 pop;
    logic                 unused_req_bits;

`ifdef XIL_MMREQ_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    assign accept          = req_wr_i && !full_q;
    assign pop             = resp_rd_i && !empty_q;
    assign unused_req_bits = ^req_dat_i[WR_BIT-1:ADR_WIDTH];

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        wr_d       = wr_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdat_d     = rdat_q;
        resp_dat_d = resp_dat_q;
`ifdef XIL_MMREQ_BRIDGE_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
`endif
        unique case (state_q)
            ADDR: begin
                if (accept) begin
                    wr_d    = req_dat_i[WR_BIT];
                    adr_d   = req_dat_i[ADR_WIDTH-1:0];
                    state_d = DATA;
                end
            end
            DATA: begin
                // Closing the request stream drops a half-received pair.
                if (!req_open_i) begin
                    state_d = ADDR;
                end else if (accept) begin
                    dat_d   = req_dat_i;
                    en_d    = 1'b1;
                    state_d = BUS;
`ifdef XIL_MMREQ_BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
`endif
                end
            end
            BUS: begin
                if (ack_i) begin
                    if (!wr_q) begin
                        rdat_d = dat_i;
                    end
                    en_d    = 1'b0;
                    state_d = RESP0;
                end
`ifdef XIL_MMREQ_BRIDGE_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        en_d    = 1'b0;
                        tmo_d   = 1'b1;
                        state_d = RESP0;
                    end
                end
`endif
            end
            RESP0: begin
                if (pop) begin
                    resp_dat_d = resp_word0(wr_q, tmo, 30'(adr_q));
                    state_d    = RESP1;
                end
            end
            RESP1: begin
                if (pop) begin
                    resp_dat_d = tmo ? TO_FILL : (wr_q ? dat_q : rdat_q);
                    state_d    = ADDR;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ADDR;
            end
        endcase
        full_d  = (state_d == BUS) || (state_d == RESP0) || (state_d == RESP1);
        empty_d = !((state_d == RESP0) || (state_d == RESP1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ADDR;
            en_q       <= 1'b0;
            wr_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdat_q     <= '0;
            resp_dat_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
`ifdef XIL_MMREQ_BRIDGE_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            wr_q       <= wr_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdat_q     <= rdat_d;
            resp_dat_q <= resp_dat_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
`ifdef XIL_MMREQ_BRIDGE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign req_full_o   = full_q;
    assign resp_empty_o = empty_q;
    assign resp_dat_o   = resp_dat_q;
    assign en_o         = en_q;
    assign wr_o         = wr_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;

endmodule

// File: tb/tb_xil_mmreq_bridge.sv
// Directed self-checking bench for xil_mmreq_bridge (timeout scenario only
// when XIL_MMREQ_BRIDGE_TIMEOUT_EN is defined).
module tb_xil_mmreq_bridge;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] req_dat_i;
    logic        req_wr_i;
    logic        req_full_o;
    logic        req_open_i;
    logic [31:0] resp_dat_o;
    logic        resp_rd_i;
    logic        resp_empty_o;
    logic        en_o;
    logic        wr_o;
    logic        ack_i;
    logic [27:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;

    logic        ack_tie;
    logic        ack_man;
    int          en_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    assign ack_i = ack_tie ? en_o : ack_man;

    always #5 clk = ~clk;

    always @(posedge clk) if (en_o) en_cnt++;

    xil_mmreq_bridge #(
        .ADR_WIDTH      (28),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_dat_i    (req_dat_i),
        .req_wr_i     (req_wr_i),
        .req_full_o   (req_full_o),
        .req_open_i   (req_open_i),
        .resp_dat_o   (resp_dat_o),
        .resp_rd_i    (resp_rd_i),
        .resp_empty_o (resp_empty_o),
        .en_o         (en_o),
        .wr_o         (wr_o),
        .ack_i        (ack_i),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .dat_i        (dat_i)
    );

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        req_dat_i = w;
        req_wr_i  = 1'b1;
        @(negedge clk);
        req_wr_i  = 1'b0;
    endtask

    task automatic pop(output logic [31:0] w);
        @(negedge clk);
        resp_rd_i = 1'b1;
        @(negedge clk);
        resp_rd_i = 1'b0;
        w = resp_dat_o;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (en_o !== 1'b0 || wr_o !== 1'b0 || adr_o !== 28'd0 || dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: en=%b wr=%b adr=%h dat=%h, expected all zero", en_o, wr_o, adr_o, dat_o);
        end
        checks++;
        if (resp_dat_o !== 32'd0 || req_full_o !== 1'b0 || resp_empty_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: resp=%h full=%b empty=%b, expected 0/0/1", resp_dat_o, req_full_o, resp_empty_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_write;
        logic [31:0] w;
        int base;
        ack_tie = 1'b1;
        base = en_cnt;
        push(32'h8000_0002);
        push(32'h1234_5678);
        checks++;
        if (en_o !== 1'b1 || wr_o !== 1'b1 || adr_o !== 28'd2 || dat_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_bus: en=%b wr=%b adr=%h dat=%h, expected 1/1/2/12345678", en_o, wr_o, adr_o, dat_o);
        end
        @(negedge clk);
        checks++;
        if (en_o !== 1'b0 || resp_empty_o !== 1'b0 || en_cnt - base != 1) begin
            errors++;
            $display("FAIL write_pulse: en=%b empty=%b en_cycles=%0d, expected 0/0/1", en_o, resp_empty_o, en_cnt - base);
        end
        pop(w);
        checks++;
        if (w !== 32'h8000_0002) begin
            errors++;
            $display("FAIL write_resp0: got %h expected 80000002", w);
        end
        pop(w);
        checks++;
        if (w !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_resp1: got %h expected 12345678", w);
        end
        checks++;
        if (resp_empty_o !== 1'b1 || req_full_o !== 1'b0) begin
            errors++;
            $display("FAIL write_idle: empty=%b full=%b expected 1/0", resp_empty_o, req_full_o);
        end
    endtask

    task automatic test_read_tied;
        logic [31:0] w;
        ack_tie = 1'b1;
        dat_i = 32'h5455_5246;
        push(32'h0000_0000);
        push(32'h0000_0000);
        checks++;
        if (en_o !== 1'b1 || wr_o !== 1'b0 || adr_o !== 28'd0) begin
            errors++;
            $display("FAIL read_bus: en=%b wr=%b adr=%h expected 1/0/0", en_o, wr_o, adr_o);
        end
        pop(w);
        checks++;
        if (w !== 32'h0000_0000) begin
            errors++;
            $display("FAIL read_resp0: got %h expected 00000000", w);
        end
        pop(w);
        checks++;
        if (w !== 32'h5455_5246) begin
            errors++;
            $display("FAIL read_resp1: got %h expected 54555246", w);
        end
    endtask

    task automatic test_delayed_ack;
        logic [31:0] w;
        int base;
        ack_tie = 1'b0;
        ack_man = 1'b0;
        dat_i = 32'hCAFE_F00D;
        base = en_cnt;
        push(32'h0000_0005);
        push(32'hDEAD_BEEF);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (en_o !== 1'b1 || adr_o !== 28'd5 || dat_o !== 32'hDEAD_BEEF || wr_o !== 1'b0 || req_full_o !== 1'b1) begin
                errors++;
                $display("FAIL delay_hold[%0d]: en=%b adr=%h dat=%h wr=%b full=%b expected 1/5/deadbeef/0/1",
                         i, en_o, adr_o, dat_o, wr_o, req_full_o);
            end
            if (i == 2) begin
                req_dat_i = 32'h8000_0077;
                req_wr_i  = 1'b1;
            end
            if (i == 3) req_wr_i = 1'b0;
            if (i == 5) ack_man = 1'b1;
            @(negedge clk);
        end
        ack_man = 1'b0;
        checks++;
        if (en_o !== 1'b0 || en_cnt - base != 5) begin
            errors++;
            $display("FAIL delay_len: en=%b en_cycles=%0d expected 0/5", en_o, en_cnt - base);
        end
        pop(w);
        checks++;
        if (w !== 32'h0000_0005 || req_full_o !== 1'b1) begin
            errors++;
            $display("FAIL delay_resp0: got %h full=%b expected 00000005/1", w, req_full_o);
        end
        pop(w);
        checks++;
        if (w !== 32'hCAFE_F00D || req_full_o !== 1'b0) begin
            errors++;
            $display("FAIL delay_resp1: got %h full=%b expected cafef00d/0", w, req_full_o);
        end
        pop(w);
        checks++;
        if (w !== 32'hCAFE_F00D || resp_empty_o !== 1'b1) begin
            errors++;
            $display("FAIL empty_read_hold: got %h empty=%b expected cafef00d/1", w, resp_empty_o);
        end
    endtask

    task automatic test_open_drop;
        logic [31:0] w;
        int base;
        ack_tie = 1'b1;
        dat_i = 32'h1111_2222;
        base = en_cnt;
        push(32'h0000_0001);
        @(negedge clk);
        req_open_i = 1'b0;
        @(negedge clk);
        req_open_i = 1'b1;
        push(32'h0000_0002);
        push(32'h0000_0000);
        checks++;
        if (en_o !== 1'b1 || adr_o !== 28'd2 || wr_o !== 1'b0) begin
            errors++;
            $display("FAIL open_bus: en=%b adr=%h wr=%b expected 1/2/0", en_o, adr_o, wr_o);
        end
        pop(w);
        checks++;
        if (w !== 32'h0000_0002 || en_cnt - base != 1) begin
            errors++;
            $display("FAIL open_resp0: got %h en_cycles=%0d expected 00000002/1", w, en_cnt - base);
        end
        pop(w);
        checks++;
        if (w !== 32'h1111_2222) begin
            errors++;
            $display("FAIL open_resp1: got %h expected 11112222", w);
        end
    endtask

    task automatic test_reset_in_bus;
        logic [31:0] w;
        ack_tie = 1'b0;
        ack_man = 1'b0;
        push(32'h8000_0004);
        push(32'hAAAA_5555);
        checks++;
        if (en_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_bus_pre: en=%b expected 1", en_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++;
        if (en_o !== 1'b0 || resp_empty_o !== 1'b1 || req_full_o !== 1'b0 || adr_o !== 28'd0) begin
            errors++;
            $display("FAIL rst_bus_post: en=%b empty=%b full=%b adr=%h expected 0/1/0/0",
                     en_o, resp_empty_o, req_full_o, adr_o);
        end
        ack_tie = 1'b1;
        push(32'h8000_0009);
        push(32'h0102_0304);
        pop(w);
        checks++;
        if (w !== 32'h8000_0009) begin
            errors++;
            $display("FAIL rst_next_resp0: got %h expected 80000009", w);
        end
        pop(w);
        checks++;
        if (w !== 32'h0102_0304) begin
            errors++;
            $display("FAIL rst_next_resp1: got %h expected 01020304", w);
        end
    endtask

`ifdef XIL_MMREQ_BRIDGE_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] w;
        int base;
        ack_tie = 1'b0;
        ack_man = 1'b0;
        base = en_cnt;
        push(32'h0000_0003);
        push(32'h0000_0000);
        for (int i = 0; i < 40 && en_o === 1'b1; i++) @(negedge clk);
        checks++;
        if (en_o !== 1'b0 || en_cnt - base != 16) begin
            errors++;
            $display("FAIL timeout_len: en=%b en_cycles=%0d expected 0/16", en_o, en_cnt - base);
        end
        pop(w);
        checks++;
        if (w !== 32'h4000_0003) begin
            errors++;
            $display("FAIL timeout_resp0: got %h expected 40000003", w);
        end
        pop(w);
        checks++;
        if (w !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL timeout_resp1: got %h expected ffffffff", w);
        end
    endtask
`endif

    initial begin
        rst_i      = 1'b1;
        req_dat_i  = 32'd0;
        req_wr_i   = 1'b0;
        req_open_i = 1'b1;
        resp_rd_i  = 1'b0;
        dat_i      = 32'd0;
        ack_tie    = 1'b1;
        ack_man    = 1'b0;
        test_reset;
        test_write;
        test_read_tied;
        test_delayed_ack;
        test_open_drop;
        test_reset_in_bus;
`ifdef XIL_MMREQ_BRIDGE_TIMEOUT_EN
        test_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
